// File: rtl/kernel_kcore_start_token_consumer_pkg.sv
// Shared definitions for the start-token consumer.
// Holds the FSM state encoding used by kernel_kcore_start_token_consumer.
package kernel_kcore_start_token_consumer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FWD   = 2'd1,
        S_START = 2'd2,
        S_RUN   = 2'd3
    } state_e;

endpackage

// File: rtl/kernel_kcore_start_token_consumer.sv
// Read-side controller for a dataflow start-token FIFO.
// Pops one start token per activation, optionally forwards it to the next
// stage's start FIFO, then runs the ap_start/ap_ready/ap_done handshake of one
// worker process. Counts completed activations and forward back-pressure cycles.
//
// Ports:
//   ap_clk, ap_rst_n          clock, async active-low reset
//   enable                    1: may pop new tokens; 0: finish current run, then hold
//   in_empty_n/in_dout/in_read    upstream start FIFO read side
//   out_full_n/out_write/out_din  downstream start FIFO write side
//   ap_start/ap_ready/ap_done     worker handshake
//   busy                      FSM not idle
//   run_count                 completed activations (wraps)
//   stall_count               cycles stalled in S_FWD (saturates)
//
// state   | meaning
// S_IDLE  | waiting for enable and a token; pops in the same cycle
// S_FWD   | pushing the popped token to the downstream start FIFO
// S_START | ap_start high, waiting for ap_ready
// S_RUN   | worker accepted, waiting for ap_done
module kernel_kcore_start_token_consumer
    import kernel_kcore_start_token_consumer_pkg::*;
#(
    parameter int DATA_WIDTH    = 1,
    parameter bit FORWARD_START = 1'b1,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  enable,
    input  logic                  in_empty_n,
    input  logic [DATA_WIDTH-1:0] in_dout,
    output logic                  in_read,
    input  logic                  out_full_n,
    output logic                  out_write,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  ap_start,
    input  logic                  ap_ready,
    input  logic                  ap_done,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  run_count,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] token_q, token_d;
    logic [CNT_WIDTH-1:0]  run_count_q, run_count_d;
    logic [CNT_WIDTH-1:0]  stall_count_q, stall_count_d;
    logic                  pop;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q       <= S_IDLE;
            token_q       <= '0;
            run_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            token_q       <= token_d;
            run_count_q   <= run_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        token_d       = token_q;
        run_count_d   = run_count_q;
        stall_count_d = stall_count_q;
        pop           = 1'b0;
        out_write     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && in_empty_n) begin
                    pop     = 1'b1;
                    token_d = in_dout;
                    state_d = FORWARD_START ? S_FWD : S_START;
                end
            end
            S_FWD: begin
                if (out_full_n) begin
                    out_write = 1'b1;
                    state_d   = S_START;
                end else if (stall_count_q != '1) begin
                    stall_count_d = stall_count_q + CNT_WIDTH'(1);
                end
            end
            S_START: begin
                // ap_done without ap_ready here is not a completed activation
                if (ap_ready) begin
                    if (ap_done) begin
                        run_count_d = run_count_q + CNT_WIDTH'(1);
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (ap_done) begin
                    run_count_d = run_count_q + CNT_WIDTH'(1);
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State is already S_IDLE during reset, so the pop strobe is masked
    // explicitly to keep the upstream FIFO untouched while reset is held.
    assign in_read     = pop & ap_rst_n;
    assign out_din     = token_q;
    assign ap_start    = (state_q == S_START);
    assign busy        = (state_q != S_IDLE);
    assign run_count   = run_count_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_kernel_kcore_start_token_consumer.sv
module tb_kernel_kcore_start_token_consumer;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;

    // instance 0: FORWARD_START = 0
    logic        en0 = 0, empty_n0 = 0, full_n0 = 0, ready0 = 0, done0 = 0;
    logic [0:0]  dout0 = '0;
    logic        in_read0, out_write0, ap_start0, busy0;
    logic [0:0]  out_din0;
    logic [31:0] run_count0, stall_count0;

    // instance 1: FORWARD_START = 1
    logic        en1 = 0, empty_n1 = 0, full_n1 = 0, ready1 = 0, done1 = 0;
    logic [0:0]  dout1 = '0;
    logic        in_read1, out_write1, ap_start1, busy1;
    logic [0:0]  out_din1;
    logic [31:0] run_count1, stall_count1;

    int n_vec = 0;
    int n_err = 0;
    int rd_pulses0 = 0;

    always #5 ap_clk = ~ap_clk;

    kernel_kcore_start_token_consumer #(
        .DATA_WIDTH(1), .FORWARD_START(1'b0), .CNT_WIDTH(32)
    ) u_dut0 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .enable(en0),
        .in_empty_n(empty_n0), .in_dout(dout0), .in_read(in_read0),
        .out_full_n(full_n0), .out_write(out_write0), .out_din(out_din0),
        .ap_start(ap_start0), .ap_ready(ready0), .ap_done(done0),
        .busy(busy0), .run_count(run_count0), .stall_count(stall_count0)
    );

    kernel_kcore_start_token_consumer #(
        .DATA_WIDTH(1), .FORWARD_START(1'b1), .CNT_WIDTH(32)
    ) u_dut1 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .enable(en1),
        .in_empty_n(empty_n1), .in_dout(dout1), .in_read(in_read1),
        .out_full_n(full_n1), .out_write(out_write1), .out_din(out_din1),
        .ap_start(ap_start1), .ap_ready(ready1), .ap_done(done1),
        .busy(busy1), .run_count(run_count1), .stall_count(stall_count1)
    );

    // FIFO protocol safety on both instances, every cycle
    always @(negedge ap_clk) begin
        if (in_read0) rd_pulses0++;
        n_vec++; if ((in_read0 & ~empty_n0) !== 1'b0) begin n_err++; $display("FAIL proto_rd0 in_read=%b in_empty_n=%b", in_read0, empty_n0); end
        n_vec++; if ((out_write0 & ~full_n0) !== 1'b0) begin n_err++; $display("FAIL proto_wr0 out_write=%b out_full_n=%b", out_write0, full_n0); end
        n_vec++; if ((in_read1 & ~empty_n1) !== 1'b0) begin n_err++; $display("FAIL proto_rd1 in_read=%b in_empty_n=%b", in_read1, empty_n1); end
        n_vec++; if ((out_write1 & ~full_n1) !== 1'b0) begin n_err++; $display("FAIL proto_wr1 out_write=%b out_full_n=%b", out_write1, full_n1); end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        #3;
        n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL rst_busy0 got %b exp 0", busy0); end
        n_vec++; if (ap_start0 !== 1'b0) begin n_err++; $display("FAIL rst_start0 got %b exp 0", ap_start0); end
        n_vec++; if (run_count0 !== 32'd0) begin n_err++; $display("FAIL rst_run0 got %0d exp 0", run_count0); end
        n_vec++; if (stall_count1 !== 32'd0) begin n_err++; $display("FAIL rst_stall1 got %0d exp 0", stall_count1); end
        n_vec++; if (out_din1 !== 1'b0) begin n_err++; $display("FAIL rst_din1 got %b exp 0", out_din1); end
        tick(); tick();
        ap_rst_n = 1'b1;
    endtask

    task automatic test_single_token();
        int rd_base;
        tick(); en0 = 1; empty_n0 = 1; dout0 = 1'b1; #1;
        n_vec++; if (in_read0 !== 1'b1) begin n_err++; $display("FAIL t1_pop got %b exp 1", in_read0); end
        n_vec++; if (ap_start0 !== 1'b0) begin n_err++; $display("FAIL t1_start_early got %b exp 0", ap_start0); end
        rd_base = rd_pulses0;
        tick(); empty_n0 = 0; #1;
        n_vec++; if (ap_start0 !== 1'b1) begin n_err++; $display("FAIL t1_start got %b exp 1", ap_start0); end
        n_vec++; if (out_din0 !== 1'b1) begin n_err++; $display("FAIL t1_token got %b exp 1", out_din0); end
        tick(); ready0 = 1; #1;
        n_vec++; if (ap_start0 !== 1'b1) begin n_err++; $display("FAIL t1_start_hold got %b exp 1", ap_start0); end
        tick(); ready0 = 0; #1;
        n_vec++; if (ap_start0 !== 1'b0) begin n_err++; $display("FAIL t1_start_fall got %b exp 0", ap_start0); end
        n_vec++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL t1_busy_run got %b exp 1", busy0); end
        tick(); tick();
        tick(); done0 = 1; #1;
        n_vec++; if (run_count0 !== 32'd0) begin n_err++; $display("FAIL t1_run_pre got %0d exp 0", run_count0); end
        tick(); done0 = 0; #1;
        n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL t1_idle got %b exp 0", busy0); end
        n_vec++; if (run_count0 !== 32'd1) begin n_err++; $display("FAIL t1_run got %0d exp 1", run_count0); end
        n_vec++; if (rd_pulses0 - rd_base !== 1) begin n_err++; $display("FAIL t1_pop_count got %0d exp 1", rd_pulses0 - rd_base); end
    endtask

    task automatic test_forward_stall();
        tick(); en1 = 1; empty_n1 = 1; dout1 = 1'b1; full_n1 = 0; #1;
        n_vec++; if (in_read1 !== 1'b1) begin n_err++; $display("FAIL t2_pop got %b exp 1", in_read1); end
        tick(); empty_n1 = 0;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) tick();
            #1;
            n_vec++; if (out_write1 !== 1'b0) begin n_err++; $display("FAIL t2_no_write[%0d] got %b exp 0", i, out_write1); end
            n_vec++; if (stall_count1 !== 32'(i)) begin n_err++; $display("FAIL t2_stall[%0d] got %0d exp %0d", i, stall_count1, i); end
        end
        tick(); full_n1 = 1; #1;
        n_vec++; if (out_write1 !== 1'b1) begin n_err++; $display("FAIL t2_write got %b exp 1", out_write1); end
        n_vec++; if (out_din1 !== 1'b1) begin n_err++; $display("FAIL t2_din got %b exp 1", out_din1); end
        n_vec++; if (stall_count1 !== 32'd5) begin n_err++; $display("FAIL t2_stall_total got %0d exp 5", stall_count1); end
        n_vec++; if (ap_start1 !== 1'b0) begin n_err++; $display("FAIL t2_start_early got %b exp 0", ap_start1); end
        tick(); #1;
        n_vec++; if (ap_start1 !== 1'b1) begin n_err++; $display("FAIL t2_start got %b exp 1", ap_start1); end
        n_vec++; if (out_write1 !== 1'b0) begin n_err++; $display("FAIL t2_write_once got %b exp 0", out_write1); end
        ready1 = 1; done1 = 1;
        tick(); ready1 = 0; done1 = 0; #1;
        n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL t2_idle got %b exp 0", busy1); end
        n_vec++; if (run_count1 !== 32'd1) begin n_err++; $display("FAIL t2_run got %0d exp 1", run_count1); end
        n_vec++; if (stall_count1 !== 32'd5) begin n_err++; $display("FAIL t2_stall_hold got %0d exp 5", stall_count1); end
    endtask

    task automatic test_back_to_back();
        int pops[4];
        int np;
        tick(); empty_n0 = 1; dout0 = 1'b0; #1;
        n_vec++; if (in_read0 !== 1'b1) begin n_err++; $display("FAIL t3_pop got %b exp 1", in_read0); end
        tick(); empty_n0 = 0; ready0 = 1; done0 = 1; #1;
        n_vec++; if (ap_start0 !== 1'b1) begin n_err++; $display("FAIL t3_start got %b exp 1", ap_start0); end
        n_vec++; if (out_din0 !== 1'b0) begin n_err++; $display("FAIL t3_token got %b exp 0", out_din0); end
        tick(); ready0 = 0; done0 = 0; #1;
        n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL t3_idle got %b exp 0", busy0); end
        n_vec++; if (run_count0 !== 32'd2) begin n_err++; $display("FAIL t3_run got %0d exp 2", run_count0); end
        // worker answers ap_ready on its first start cycle and ap_done one cycle later
        np = 0;
        for (int c = 0; c < 9; c++) begin
            tick();
            empty_n0 = 1;
            ready0 = ap_start0;
            done0 = busy0 & ~ap_start0;
            #1;
            if (in_read0 && np < 4) begin pops[np] = c; np++; end
        end
        tick(); empty_n0 = 0; ready0 = 0; done0 = 0; #1;
        n_vec++; if (np !== 3) begin n_err++; $display("FAIL t3_b2b_pops got %0d exp 3", np); end
        n_vec++; if (np == 3 && (pops[0] !== 0 || pops[1] !== 3 || pops[2] !== 6)) begin n_err++; $display("FAIL t3_b2b_spacing got %0d,%0d,%0d exp 0,3,6", pops[0], pops[1], pops[2]); end
        n_vec++; if (run_count0 !== 32'd5) begin n_err++; $display("FAIL t3_b2b_run got %0d exp 5", run_count0); end
        n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL t3_b2b_idle got %b exp 0", busy0); end
    endtask

    task automatic test_enable();
        tick(); en0 = 0; empty_n0 = 1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) tick();
            #1;
            n_vec++; if (in_read0 !== 1'b0) begin n_err++; $display("FAIL t4_disabled_rd[%0d] got %b exp 0", i, in_read0); end
            n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL t4_disabled_busy[%0d] got %b exp 0", i, busy0); end
        end
        tick(); en0 = 1; #1;
        n_vec++; if (in_read0 !== 1'b1) begin n_err++; $display("FAIL t4_pop got %b exp 1", in_read0); end
        tick(); en0 = 0; ready0 = 1; #1;
        n_vec++; if (ap_start0 !== 1'b1) begin n_err++; $display("FAIL t4_start got %b exp 1", ap_start0); end
        tick(); ready0 = 0; #1;
        n_vec++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL t4_run_busy got %b exp 1", busy0); end
        tick(); done0 = 1; #1;
        n_vec++; if (in_read0 !== 1'b0) begin n_err++; $display("FAIL t4_run_rd got %b exp 0", in_read0); end
        tick(); done0 = 0; #1;
        n_vec++; if (run_count0 !== 32'd6) begin n_err++; $display("FAIL t4_run got %0d exp 6", run_count0); end
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            n_vec++; if (in_read0 !== 1'b0) begin n_err++; $display("FAIL t4_hold_rd[%0d] got %b exp 0", i, in_read0); end
            n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL t4_hold_busy[%0d] got %b exp 0", i, busy0); end
        end
        tick(); empty_n0 = 0;
    endtask

    task automatic test_spurious_done();
        tick(); done0 = 1; done1 = 1; #1;
        n_vec++; if (in_read0 !== 1'b0) begin n_err++; $display("FAIL t6_rd0 got %b exp 0", in_read0); end
        n_vec++; if (out_write1 !== 1'b0) begin n_err++; $display("FAIL t6_wr1 got %b exp 0", out_write1); end
        n_vec++; if (ap_start1 !== 1'b0) begin n_err++; $display("FAIL t6_start1 got %b exp 0", ap_start1); end
        tick();
        tick(); done0 = 0; done1 = 0; #1;
        n_vec++; if (run_count0 !== 32'd6) begin n_err++; $display("FAIL t6_run0 got %0d exp 6", run_count0); end
        n_vec++; if (run_count1 !== 32'd1) begin n_err++; $display("FAIL t6_run1 got %0d exp 1", run_count1); end
        n_vec++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin n_err++; $display("FAIL t6_busy got %b%b exp 00", busy0, busy1); end
    endtask

    task automatic test_reset_mid_run();
        tick(); en0 = 1; empty_n0 = 1; dout0 = 1'b1; #1;
        n_vec++; if (in_read0 !== 1'b1) begin n_err++; $display("FAIL t5_pop got %b exp 1", in_read0); end
        tick(); ready0 = 1; #1;
        tick(); ready0 = 0; #1;
        n_vec++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL t5_run_busy got %b exp 1", busy0); end
        tick(); ap_rst_n = 0; #1;
        n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL t5_rst_busy got %b exp 0", busy0); end
        n_vec++; if (ap_start0 !== 1'b0) begin n_err++; $display("FAIL t5_rst_start got %b exp 0", ap_start0); end
        n_vec++; if (in_read0 !== 1'b0) begin n_err++; $display("FAIL t5_rst_rd got %b exp 0", in_read0); end
        n_vec++; if (out_din0 !== 1'b0) begin n_err++; $display("FAIL t5_rst_token got %b exp 0", out_din0); end
        n_vec++; if (run_count0 !== 32'd0) begin n_err++; $display("FAIL t5_rst_run0 got %0d exp 0", run_count0); end
        n_vec++; if (run_count1 !== 32'd0) begin n_err++; $display("FAIL t5_rst_run1 got %0d exp 0", run_count1); end
        n_vec++; if (stall_count1 !== 32'd0) begin n_err++; $display("FAIL t5_rst_stall1 got %0d exp 0", stall_count1); end
        tick();
        tick(); ap_rst_n = 1; #1;
        n_vec++; if (in_read0 !== 1'b1) begin n_err++; $display("FAIL t5_fresh_pop got %b exp 1", in_read0); end
        tick(); empty_n0 = 0; ready0 = 1; done0 = 1; #1;
        n_vec++; if (ap_start0 !== 1'b1) begin n_err++; $display("FAIL t5_fresh_start got %b exp 1", ap_start0); end
        n_vec++; if (out_din0 !== 1'b1) begin n_err++; $display("FAIL t5_fresh_token got %b exp 1", out_din0); end
        tick(); ready0 = 0; done0 = 0; #1;
        n_vec++; if (run_count0 !== 32'd1) begin n_err++; $display("FAIL t5_fresh_run got %0d exp 1", run_count0); end
        n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL t5_fresh_idle got %b exp 0", busy0); end
    endtask

    initial begin
        test_reset();
        test_single_token();
        test_forward_stall();
        test_back_to_back();
        test_enable();
        test_spurious_done();
        test_reset_mid_run();
        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
